// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART TX enqueue port
// among up to eight byte-stream requesters, with FIFO-lag hold-off and stall timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 start_uart_tx,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_fifo_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 msg_done,
  output logic                 timeout_err
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state, state_nxt;
  logic [2:0]  grant, rr_ptr, winner, next_ptr;
  logic [15:0] stall_cnt;
  logic [1:0]  holdoff;
  logic [7:0]  valid_pad, last_pad, ready_pad, sel_data;
  logic [3:0]  scan;
  logic        found, g_valid, g_last, can_take, hs, stall, tout, msg_end;

  logic        vld_p1;
  logic [7:0]  data_p1;
  logic        done_p1, tout_p1;

  assign valid_pad = 8'(req_valid);
  assign last_pad  = 8'(req_last);
  assign g_valid   = valid_pad[grant];
  assign g_last    = last_pad[grant];
  assign next_ptr  = (grant == 3'(NUM_REQ - 1)) ? 3'd0 : grant + 3'd1;

  // Lowest valid index at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    scan   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr} + 4'(i);
      if (scan >= 4'(NUM_REQ)) scan = scan - 4'(NUM_REQ);
      if (!found && valid_pad[scan[2:0]]) begin
        found  = 1'b1;
        winner = scan[2:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant == 3'(i)) sel_data = req_data[8*i +: 8];
  end

  // Hold-off masks the cycles where uart_tx_fifo_ready does not yet reflect our enqueue.
  assign can_take = (state == XFER) && uart_tx_fifo_ready && (holdoff == 2'd0);
  assign hs       = can_take && g_valid;
  assign stall    = (state == XFER) && !g_valid;
  assign tout     = (TIMEOUT_CYCLES != 0) && stall &&
                    (({1'b0, stall_cnt} + 17'd1) >= 17'(TIMEOUT_CYCLES));
  assign msg_end  = (hs && g_last) || tout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)   state_nxt = XFER;
      XFER:    if (msg_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_pad        = '0;
    ready_pad[grant] = can_take;
    req_ready        = ready_pad[NUM_REQ-1:0];
    busy             = (state == XFER);
    grant_id         = grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant     <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
      holdoff   <= '0;
    end else begin
      if (hs)                 holdoff <= 2'd2;
      else if (holdoff != '0) holdoff <= holdoff - 2'd1;
      if (state == IDLE) begin
        if (found) begin
          grant     <= winner;
          stall_cnt <= '0;
        end
      end else begin
        if (g_valid)                    stall_cnt <= '0;
        else if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        if (msg_end) rr_ptr <= next_ptr;
      end
    end
  end

  // Stage p1: enqueue strobe and message status one cycle after the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      done_p1 <= 1'b0;
      tout_p1 <= 1'b0;
    end else begin
      vld_p1  <= hs;
      if (hs) data_p1 <= sel_data;
      done_p1 <= hs && g_last;
      tout_p1 <= tout;
    end
  end

  assign start_uart_tx = vld_p1;
  assign uart_tx_data  = data_p1;
  assign msg_done      = done_p1;
  assign timeout_err   = tout_p1;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed messages push expected strobes/grants,
// a monitor pops and compares whenever the DUT strobes or starts a grant.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        start_uart_tx;
  logic [7:0]  uart_tx_data;
  logic        fifo_ready = 1'b0;
  logic [2:0]  grant_id;
  logic        busy, msg_done, timeout_err;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .start_uart_tx(start_uart_tx),
    .uart_tx_data(uart_tx_data), .uart_tx_fifo_ready(fifo_ready), .grant_id(grant_id),
    .busy(busy), .msg_done(msg_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  logic [8:0] rmem [4][32];
  int rhead [4];
  int rtail [4];
  logic [8:0] exp_q[$];
  logic [2:0] grant_q[$];
  int stb_cyc[$];
  int stb_cnt = 0, tout_cnt = 0, last_stb_cyc = 0;
  logic busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic load(input int r, input logic [7:0] b, input logic last);
    rmem[r][rtail[r]] = {last, b};
    rtail[r]++;
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  function automatic bit reqs_empty();
    for (int i = 0; i < 4; i++) if (rhead[i] < rtail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (n < max_cyc && !(exp_q.size() == 0 && grant_q.size() == 0 && !busy && reqs_empty())) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (n >= max_cyc) begin
      miscompares++;
      $display("FAIL %s_drain: %0d strobes and %0d grants still pending after %0d cycles, required 0",
               name, exp_q.size(), grant_q.size(), max_cyc);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_reqs();
    exp_q.delete();
    grant_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_start"},   32'(start_uart_tx), 32'd0);
    check({tag, "_data"},    32'(uart_tx_data),  32'd0);
    check({tag, "_ready"},   32'(req_ready),     32'd0);
    check({tag, "_grant"},   32'(grant_id),      32'd0);
    check({tag, "_busy"},    32'(busy),          32'd0);
    check({tag, "_done"},    32'(msg_done),      32'd0);
    check({tag, "_timeout"}, 32'(timeout_err),   32'd0);
  endtask

  // Requester driver: advance on handshakes, present the head of each queue.
  initial begin
    logic [3:0] hs;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i] && rhead[i] < rtail[i]) rhead[i]++;
        if (rhead[i] < rtail[i]) begin
          req_valid[i]         = 1'b1;
          req_data[8*i +: 8]   = rmem[i][rhead[i]][7:0];
          req_last[i]          = rmem[i][rhead[i]][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every strobe and every new grant.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_prev = 1'b0;
        continue;
      end
      if (start_uart_tx) begin
        stb_cnt++;
        stb_cyc.push_back(cyc);
        last_stb_cyc = cyc;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got data %02h, no strobe expected", uart_tx_data);
        end else begin
          e = exp_q.pop_front();
          check("strobe_data", 32'(uart_tx_data), 32'(e[7:0]));
          check("msg_done_with_strobe", 32'(msg_done), 32'(e[8]));
        end
      end else if (msg_done) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_msg_done: got 1 without strobe, required 0");
      end
      if (timeout_err) tout_cnt++;
      if (busy && !busy_prev) begin
        if (grant_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_grant: got grant %0d, none expected", grant_id);
        end else begin
          check("grant_id", 32'(grant_id), 32'(grant_q.pop_front()));
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    int s0, t0, n;
    clear_reqs();
    fifo_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Contention: requesters 1 and 2 together, rr_ptr = 0
    load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b1);
    load(2, 8'h21, 1'b0); load(2, 8'h22, 1'b1);
    grant_q.push_back(3'd1); grant_q.push_back(3'd2);
    expect_byte(8'h11, 1'b0); expect_byte(8'h12, 1'b1);
    expect_byte(8'h21, 1'b0); expect_byte(8'h22, 1'b1);
    wait_idle("contention", 200);

    // Single message on requester 0
    stb_cyc.delete();
    load(0, 8'h48, 1'b0); load(0, 8'h69, 1'b0); load(0, 8'h0A, 1'b1);
    grant_q.push_back(3'd0);
    expect_byte(8'h48, 1'b0); expect_byte(8'h69, 1'b0); expect_byte(8'h0A, 1'b1);
    wait_idle("single", 200);
    check("single_strobe_count", 32'(stb_cyc.size()), 32'd3);
    if (stb_cyc.size() == 3) begin
      check("single_spacing_1", 32'(stb_cyc[1] - stb_cyc[0]), 32'd3);
      check("single_spacing_2", 32'(stb_cyc[2] - stb_cyc[1]), 32'd3);
    end
    check("single_busy_after", 32'(busy), 32'd0);

    // Fairness: all four send 1-byte messages equal to their index
    apply_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) load(i, 8'(i), 1'b1);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        grant_q.push_back(3'(i));
        expect_byte(8'(i), 1'b1);
      end
    wait_idle("fairness", 400);

    // Backpressure: FIFO not ready for 100 cycles mid-message
    load(2, 8'h31, 1'b0); load(2, 8'h32, 1'b0); load(2, 8'h33, 1'b1);
    grant_q.push_back(3'd2);
    expect_byte(8'h31, 1'b0); expect_byte(8'h32, 1'b0); expect_byte(8'h33, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!start_uart_tx && n < 50);
    check("bp_first_strobe_seen", 32'(start_uart_tx), 32'd1);
    @(posedge clk); #1;
    fifo_ready = 1'b0;
    s0 = stb_cnt;
    t0 = tout_cnt;
    repeat (100) @(posedge clk);
    #1;
    check("bp_strobes_while_stalled", 32'(stb_cnt - s0), 32'd0);
    check("bp_timeouts_while_stalled", 32'(tout_cnt - t0), 32'd0);
    fifo_ready = 1'b1;
    wait_idle("backpressure", 200);

    // Timeout: requester 3 sends one byte without last, then goes quiet
    load(3, 8'h5A, 1'b0);
    grant_q.push_back(3'd3);
    expect_byte(8'h5A, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout_err && n < 100);
    check("timeout_pulse", 32'(timeout_err), 32'd1);
    check("timeout_delay", 32'(cyc - last_stb_cyc), 32'd16);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_no_done", 32'(msg_done), 32'd0);
    load(3, 8'h61, 1'b1);
    load(0, 8'h60, 1'b1);
    grant_q.push_back(3'd0); grant_q.push_back(3'd3);
    expect_byte(8'h60, 1'b1); expect_byte(8'h61, 1'b1);
    wait_idle("after_timeout", 200);

    // Reset during a strobe cycle
    load(1, 8'h70, 1'b0); load(1, 8'h71, 1'b0); load(1, 8'h72, 1'b1);
    grant_q.push_back(3'd1);
    expect_byte(8'h70, 1'b0); expect_byte(8'h71, 1'b0); expect_byte(8'h72, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!start_uart_tx && n < 50);
    check("midreset_strobe_seen", 32'(start_uart_tx), 32'd1);
    #1;
    reset_n = 1'b0;
    clear_reqs();
    exp_q.delete();
    grant_q.delete();
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    load(2, 8'h82, 1'b1);
    load(0, 8'h80, 1'b1);
    grant_q.push_back(3'd0); grant_q.push_back(3'd2);
    expect_byte(8'h80, 1'b1); expect_byte(8'h82, 1'b1);
    wait_idle("post_reset", 200);

    check("final_strobes_left", 32'(exp_q.size()), 32'd0);
    check("final_grants_left", 32'(grant_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among up to eight byte-stream requesters. Arbitration is round-robin at message granularity: bytes of different messages never interleave. The block sits between the application sources (debug printers, command responders, status reporters) and the UART's `start_uart_tx` / `uart_tx_data` / `uart_tx_fifo_ready` enqueue port. It paces enqueues so that no byte is ever dropped by the UART TX FIFO.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `TIMEOUT_CYCLES`, default 65535: consecutive stall cycles before a granted message is aborted; legal range 1..65535; 0 disables the timeout.

**Ports**
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: per requester, a byte is offered.
- `req_data` input 8*NUM_REQ: byte for requester i, at bits [8i+7:8i].
- `req_last` input NUM_REQ: offered byte is the final byte of its message.
- `req_ready` output NUM_REQ: byte accepted this cycle when `req_valid[i] && req_ready[i]`; combinational.
- `start_uart_tx` output 1: registered one-cycle enqueue strobe to the UART.
- `uart_tx_data` output 8: registered byte, valid while `start_uart_tx` is high.
- `uart_tx_fifo_ready` input 1: UART TX FIFO can accept a byte; lags the FIFO count by one cycle.
- `grant_id` output 3: index of the current owner; meaningful while `busy` is high.
- `busy` output 1: a message is in progress.
- `msg_done` output 1: one-cycle pulse after the last byte of a message is accepted.
- `timeout_err` output 1: one-cycle pulse when a message is aborted.

## Operation

**States**
- IDLE: no owner.
- XFER: a message is owned by `grant_id`.

**IDLE**
- If any `req_valid` bit is high, grant the lowest index at or above `rr_ptr`, wrapping modulo NUM_REQ.
- Next cycle: state XFER, `busy`=1, `grant_id` = the winner, stall counter = 0.
- `req_ready` is all zeros in IDLE.

**XFER**
- `req_ready[g]` = `uart_tx_fifo_ready && holdoff==0`. All other `req_ready` bits are 0.
- On a handshake, the next cycle has `start_uart_tx`=1 and `uart_tx_data` = `req_data[g]`.
- Hold-off: after a handshake in cycle h, `req_ready` is forced low in cycles h+1 and h+2. This covers the one-cycle lag of `uart_tx_fifo_ready`, so the maximum rate is one byte per 3 cycles.
- Handshake with `req_last[g]`=1: next cycle is IDLE with `busy`=0, `msg_done`=1, and `rr_ptr` = (g+1) mod NUM_REQ. The final `start_uart_tx` pulse and the `msg_done` pulse occur in the same cycle.
- Stall counter (16-bit, saturating):
  - increments each XFER cycle in which `req_valid[g]`=0;
  - clears on any cycle in which `req_valid[g]`=1.
  - A cycle with `uart_tx_fifo_ready` low and `req_valid[g]` high is not a stall.
- When the stall counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES is nonzero), the next cycle has `timeout_err`=1, state IDLE, `busy`=0, and `rr_ptr` = g+1. Bytes already enqueued stay enqueued; there is no `msg_done`.

**Other rules**
- `req_valid` on a non-granted requester is ignored; it holds until that requester wins.
- `req_last` on a zero-length message is not possible: every message carries at least one byte.
- NUM_REQ < 8: unused `grant_id` codes are never produced. Requesters whose `req_valid` bit is permanently low are skipped without costing cycles.

**Reset**
- Asserting `reset_n` low immediately forces:
  - all outputs to 0;
  - state IDLE, `rr_ptr`=0, stall counter 0, hold-off 0.
- This applies mid-message as well. A byte whose strobe was pending is lost, and the requester must restart the message.

## Timing
- Reset values: `start_uart_tx`=0, `uart_tx_data`=8'h00, `req_ready`=0, `grant_id`=0, `busy`=0, `msg_done`=0, `timeout_err`=0.
- Arbitration latency: `req_valid` rising in IDLE at cycle t gives `busy`=1 at t+1. The earliest handshake is at t+1, with the strobe at t+2.
- Handshake-to-strobe latency: 1 cycle. Strobe spacing: at least 3 cycles.
- Back-to-back messages: last byte handshake at h, then IDLE at h+1, then the next grant at h+2. Minimum idle gap is 1 cycle.
- `req_ready` depends combinationally only on registered state and `uart_tx_fifo_ready`, never on `req_valid`.

## Test plan
- **Single message:** requester 0 sends 0x48, 0x69, 0x0A with `req_last` on 0x0A, `uart_tx_fifo_ready`=1 → three strobes carrying 0x48, 0x69, 0x0A exactly 3 cycles apart, `msg_done` once coinciding with the third strobe, `busy` low afterwards.
- **Contention:** with `rr_ptr`=0, requesters 1 and 2 become valid in the same cycle with 2-byte messages {0x11,0x12} and {0x21,0x22} → strobes 0x11, 0x12, 0x21, 0x22 with no interleaving; `grant_id` is 1 then 2.
- **Fairness:** NUM_REQ=4, all requesters continuously send 1-byte messages equal to their index → grant sequence 0, 1, 2, 3, 0, 1 and strobe data following the same order.
- **Backpressure:** hold `uart_tx_fifo_ready` low for 100 cycles mid-message with `req_valid` high and TIMEOUT_CYCLES=16 → zero strobes and no `timeout_err`; after release, the remaining bytes go out in order and none are lost.
- **Timeout:** TIMEOUT_CYCLES=16; requester 3 sends 1 byte without `req_last`, then drops `req_valid` → `timeout_err` pulses 16 cycles after the drop, `busy`=0, and the next grant goes to requester 0.
- **Reset mid-message:** pull `reset_n` low during a strobe cycle → all outputs 0 within the same cycle. After release, requesters 2 and 0 become valid together → requester 0 is granted first (`rr_ptr`=0).
